tmds_align_ctrl: RTL and testbench

- Word-alignment and lock controller for one TMDS channel, between the 1:10 deserializer and the TMDS decoder.
- Selects the 10-bit window from the raw deserialized stream by searching slip offsets for DVI control-token runs in blanking.
- Declares lock and drives the decoder enable, so the decoder only processes aligned words and holds its outputs otherwise.
- Loses lock on repeated bad token runs and re-searches.

---
 rtl/tmds_pkg.sv | 21 ++
 rtl/tmds_word_aligner.sv | 32 +++
 rtl/tmds_align_ctrl.sv | 144 ++++++++++++++
 tb/tb_tmds_align_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: the four DVI control tokens, alignment FSM states
// and the token classifier used by the aligner, decoder and sync logic.
package tmds_pkg;

    localparam logic [9:0] CTRL_TOK_0 = 10'b1101010100;
    localparam logic [9:0] CTRL_TOK_1 = 10'b0010101011;
    localparam logic [9:0] CTRL_TOK_2 = 10'b0101010100;
    localparam logic [9:0] CTRL_TOK_3 = 10'b1010101011;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } align_state_e;

    function automatic logic is_ctrl_token(input logic [9:0] word);
        return (word == CTRL_TOK_0) || (word == CTRL_TOK_1) ||
               (word == CTRL_TOK_2) || (word == CTRL_TOK_3);
    endfunction

endpackage

// File: rtl/tmds_word_aligner.sv
// Holds the previous deserializer word and selects a 10-bit window from the
// 20-bit {current, previous} pair at the given slip offset.
module tmds_word_aligner
    import tmds_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] raw_in,
    input  logic       raw_valid,
    input  logic [3:0] slip_pos,
    input  logic       discard,
    output logic [9:0] word
);

    logic [9:0]  prev;
    logic [19:0] pair;

    // A slip throws away the straddling word so the new window starts clean.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= '0;
        end else if (discard) begin
            prev <= '0;
        end else if (raw_valid) begin
            prev <= raw_in;
        end
    end

    assign pair = {raw_in, prev};
    assign word = 10'(pair >> slip_pos);

endmodule

// File: rtl/tmds_align_ctrl.sv
// Word-alignment and lock controller for one TMDS channel: hunts slip offsets
// for control-token runs, declares lock and gates the decoder enable.
module tmds_align_ctrl
    import tmds_pkg::*;
#(
    parameter int MIN_RUN      = 8,
    parameter int LOCK_RUNS    = 4,
    parameter int ERR_LIMIT    = 4,
    parameter int SEARCH_WORDS = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] raw_in,
    input  logic       raw_valid,
    output logic [9:0] tmds_out,
    output logic       tmds_valid,
    output logic       dec_en,
    output logic [3:0] slip_pos,
    output logic       locked,
    output logic       ctrl_tok,
    output logic       lock_lost
);

    localparam int RUN_W  = $clog2(MIN_RUN + 1);
    localparam int IDLE_W = $clog2(SEARCH_WORDS);
    localparam int GOOD_W = $clog2(LOCK_RUNS + 1);
    localparam int ERR_W  = $clog2(ERR_LIMIT + 1);

    localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(MIN_RUN);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(SEARCH_WORDS - 1);
    localparam logic [GOOD_W-1:0] GOOD_MAX  = GOOD_W'(LOCK_RUNS);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_RUNS - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX   = ERR_W'(ERR_LIMIT);
    localparam logic [ERR_W-1:0]  ERR_LAST  = ERR_W'(ERR_LIMIT - 1);

    align_state_e       state, state_next;
    logic [RUN_W-1:0]   run_len;
    logic [IDLE_W-1:0]  idle_cnt;
    logic [GOOD_W-1:0]  good_cnt;
    logic [ERR_W-1:0]   err_cnt;
    logic [9:0]         word;
    logic               tok, good_end, bad_end, timeout, slip;

    tmds_word_aligner u_aligner (
        .clk       (clk),
        .rst       (rst),
        .raw_in    (raw_in),
        .raw_valid (raw_valid),
        .slip_pos  (slip_pos),
        .discard   (slip),
        .word      (word)
    );

    assign tok      = is_ctrl_token(word);
    assign good_end = raw_valid & ~tok & (run_len == RUN_MAX);
    assign bad_end  = raw_valid & ~tok & (run_len != '0) & (run_len != RUN_MAX);
    // A run event on the same word takes precedence over the idle timeout.
    assign timeout  = raw_valid & (idle_cnt == IDLE_MAX) & ~good_end & ~bad_end;

    always_comb begin
        state_next = state;
        slip       = 1'b0;
        case (state)
            SEARCH: begin
                if (good_end) begin
                    state_next = VERIFY;
                end else if (timeout) begin
                    slip = 1'b1;
                end
            end
            VERIFY: begin
                if (good_end) begin
                    if (good_cnt == GOOD_LAST) state_next = LOCKED;
                end else if (bad_end || timeout) begin
                    slip       = 1'b1;
                    state_next = SEARCH;
                end
            end
            LOCKED: begin
                if ((bad_end && err_cnt == ERR_LAST) || timeout) state_next = SEARCH;
            end
            default: state_next = SEARCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SEARCH;
            slip_pos   <= '0;
            run_len    <= '0;
            idle_cnt   <= '0;
            good_cnt   <= '0;
            err_cnt    <= '0;
            tmds_out   <= '0;
            tmds_valid <= 1'b0;
            dec_en     <= 1'b0;
            locked     <= 1'b0;
            ctrl_tok   <= 1'b0;
            lock_lost  <= 1'b0;
        end else begin
            lock_lost  <= 1'b0;
            tmds_valid <= raw_valid;
            locked     <= (state_next == LOCKED);
            dec_en     <= raw_valid & (state_next == LOCKED);
            if (raw_valid) begin
                tmds_out <= word;
                ctrl_tok <= tok;

                if (!tok)                  run_len <= '0;
                else if (run_len != RUN_MAX) run_len <= run_len + 1'b1;

                if (good_end || state_next != state) idle_cnt <= '0;
                else if (idle_cnt != IDLE_MAX)        idle_cnt <= idle_cnt + 1'b1;

                case (state)
                    SEARCH: if (good_end) good_cnt <= GOOD_W'(1);
                    VERIFY: if (good_end && good_cnt != GOOD_MAX) good_cnt <= good_cnt + 1'b1;
                    LOCKED: begin
                        if (good_end)                        err_cnt <= '0;
                        else if (bad_end && err_cnt != ERR_MAX) err_cnt <= err_cnt + 1'b1;
                    end
                    default: ;
                endcase

                if (state_next != state) begin
                    err_cnt <= '0;
                    if (state_next == SEARCH) good_cnt <= '0;
                end

                // Lock loss keeps the offset so relock can happen in place.
                if (slip) begin
                    slip_pos <= (slip_pos == 4'd9) ? 4'd0 : slip_pos + 4'd1;
                    run_len  <= '0;
                    idle_cnt <= '0;
                    good_cnt <= '0;
                end

                lock_lost <= (state == LOCKED) && (state_next != LOCKED);
                state     <= state_next;
            end
        end
    end

endmodule

// File: tb/tb_tmds_align_ctrl.sv
// Randomized scoreboard bench for tmds_align_ctrl: a bit-stream generator feeds
// the DUT and an abstract per-word reference model fills the expected queue.
module tb_tmds_align_ctrl;

    localparam int MIN_RUN   = 8;
    localparam int LOCK_RUNS = 4;
    localparam int ERR_LIMIT = 4;
    localparam int SW        = 64;
    localparam int M_SEARCH  = 0;
    localparam int M_VERIFY  = 1;
    localparam int M_LOCKED  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] raw_in = '0;
    logic       raw_valid = 1'b0;
    logic [9:0] tmds_out;
    logic       tmds_valid, dec_en, locked, ctrl_tok, lock_lost;
    logic [3:0] slip_pos;

    tmds_align_ctrl #(
        .MIN_RUN      (MIN_RUN),
        .LOCK_RUNS    (LOCK_RUNS),
        .ERR_LIMIT    (ERR_LIMIT),
        .SEARCH_WORDS (SW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .raw_in     (raw_in),
        .raw_valid  (raw_valid),
        .tmds_out   (tmds_out),
        .tmds_valid (tmds_valid),
        .dec_en     (dec_en),
        .slip_pos   (slip_pos),
        .locked     (locked),
        .ctrl_tok   (ctrl_tok),
        .lock_lost  (lock_lost)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] out;
        logic       vld;
        logic       den;
        logic [3:0] slip;
        logic       lck;
        logic       tok;
        logic       lost;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    logic [9:0] tokens [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

    // Reference model state
    int         m_mode, m_slip, m_run, m_idle, m_goods, m_errs;
    logic [9:0] m_prev;
    exp_t       m_out;
    bit         bits[$];

    function automatic bit is_tok(input logic [9:0] w);
        for (int i = 0; i < 4; i++) if (w == tokens[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [9:0] rand_data();
        logic [9:0] w;
        do w = 10'($urandom); while (is_tok(w));
        return w;
    endfunction

    task automatic model_step(input bit r, input logic [9:0] raw, input bit v);
        logic [19:0] pair;
        logic [9:0]  win;
        bit          tok, good, bad, tmo, slip;
        int          nxt;
        if (r) begin
            m_mode = M_SEARCH; m_slip = 0; m_run = 0; m_idle = 0;
            m_goods = 0; m_errs = 0; m_prev = '0; m_out = '0;
            return;
        end
        m_out.lost = 1'b0;
        m_out.vld  = v;
        m_out.den  = 1'b0;
        if (!v) return;
        pair = {raw, m_prev};
        win  = 10'(pair >> m_slip);
        tok  = is_tok(win);
        m_out.out = win;
        m_out.tok = tok;
        good = 0; bad = 0;
        if (tok) begin
            m_run = (m_run < MIN_RUN) ? m_run + 1 : MIN_RUN;
        end else begin
            good  = (m_run == MIN_RUN);
            bad   = (m_run > 0) && (m_run < MIN_RUN);
            m_run = 0;
        end
        tmo    = (m_idle == SW - 1) && !good && !bad;
        m_idle = good ? 0 : ((m_idle < SW - 1) ? m_idle + 1 : m_idle);
        slip = 0;
        nxt  = m_mode;
        case (m_mode)
            M_SEARCH: begin
                if (good) begin nxt = M_VERIFY; m_goods = 1; end
                else if (tmo) slip = 1;
            end
            M_VERIFY: begin
                if (good) begin
                    m_goods++;
                    if (m_goods == LOCK_RUNS) nxt = M_LOCKED;
                end else if (bad || tmo) begin
                    slip = 1; nxt = M_SEARCH;
                end
            end
            default: begin
                if (good) m_errs = 0;
                else if (bad) begin
                    m_errs++;
                    if (m_errs == ERR_LIMIT) nxt = M_SEARCH;
                end else if (tmo) nxt = M_SEARCH;
            end
        endcase
        m_prev = raw;
        if (slip) begin
            m_slip = (m_slip + 1) % 10;
            m_run = 0; m_idle = 0; m_goods = 0; m_prev = '0;
        end
        if (nxt != m_mode) begin
            m_idle = 0;
            if (m_mode == M_LOCKED) begin
                m_out.lost = 1'b1; m_goods = 0; m_errs = 0;
            end
        end
        m_mode     = nxt;
        m_out.lck  = (m_mode == M_LOCKED);
        m_out.den  = m_out.lck;
        m_out.slip = 4'(m_slip);
    endtask

    task automatic cycle(input bit r, input logic [9:0] raw, input bit v);
        @(negedge clk);
        rst       = r;
        raw_in    = raw;
        raw_valid = v;
        model_step(r, raw, v);
        exp_q.push_back(m_out);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic dcheck(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic push_sym(input logic [9:0] s);
        for (int i = 0; i < 10; i++) bits.push_back(s[i]);
    endtask

    task automatic set_offset(input int k);
        bits.delete();
        for (int i = 0; i < k; i++) bits.push_back(1'($urandom));
    endtask

    task automatic flush(input int gap_pct);
        logic [9:0] w;
        while (bits.size() >= 10) begin
            for (int i = 0; i < 10; i++) w[i] = bits.pop_front();
            if (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct)
                cycle(1'b0, 10'($urandom), 1'b0);
            cycle(1'b0, w, 1'b1);
        end
    endtask

    task automatic run_seg(input int ntok, input int ndata, input bit single, input int gap_pct);
        for (int i = 0; i < ntok; i++) push_sym(single ? tokens[0] : tokens[$urandom_range(0, 3)]);
        for (int i = 0; i < ndata; i++) push_sym(rand_data());
        flush(gap_pct);
    endtask

    // Monitor: one expected record per clock, compared after the edge
    initial begin
        exp_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{tmds_out, tmds_valid, dec_en, slip_pos, locked, ctrl_tok, lock_lost};
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL outputs @%0t got out=%h vld=%b den=%b slip=%0d lck=%b tok=%b lost=%b want out=%h vld=%b den=%b slip=%0d lck=%b tok=%b lost=%b",
                             $time, a.out, a.vld, a.den, a.slip, a.lck, a.tok, a.lost,
                             e.out, e.vld, e.den, e.slip, e.lck, e.tok, e.lost);
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        model_step(1'b1, '0, 1'b0);

        // Reset with random inputs
        repeat (3) cycle(1'b1, 10'($urandom), 1'($urandom));
        settle();
        dcheck("reset_slip", slip_pos, 0);
        dcheck("reset_locked", locked, 0);

        // Search, verify and lock at true offset 3
        set_offset(3);
        repeat (12) run_seg(20, 40, 1'b1, 0);
        settle();
        dcheck("align_slip", slip_pos, 3);
        dcheck("align_locked", locked, 1);

        // Valid gap in the middle of a run
        for (int i = 0; i < 5; i++) push_sym(tokens[0]);
        flush(0);
        repeat (5) cycle(1'b0, 10'($urandom), 1'b0);
        run_seg(15, 2, 1'b1, 0);

        // Four short runs drop lock without moving the offset
        repeat (4) run_seg(2, 5, 1'b1, 0);
        settle();
        dcheck("loss_locked", locked, 0);
        dcheck("loss_slip", slip_pos, 3);
        repeat (6) run_seg(20, 40, 1'b1, 0);
        settle();
        dcheck("relock_locked", locked, 1);
        dcheck("relock_slip", slip_pos, 3);

        // Reset while locked
        cycle(1'b1, 10'($urandom), 1'b1);
        settle();
        dcheck("rst_lock_lost", lock_lost, 0);
        dcheck("rst_locked", locked, 0);
        dcheck("rst_dec_en", dec_en, 0);
        dcheck("rst_slip", slip_pos, 0);

        // Wrap-around: data-only stream walks slip to 9, then lock at 0
        set_offset(0);
        guard = 0;
        while (m_slip != 9 && guard < 2000) begin
            run_seg(0, 1, 1'b1, 0);
            guard++;
        end
        settle();
        dcheck("wrap_slip9", slip_pos, 9);
        repeat (12) run_seg(20, 40, 1'b1, 0);
        settle();
        dcheck("wrap_slip0", slip_pos, 0);
        dcheck("wrap_locked", locked, 1);

        // Bad run while verifying
        cycle(1'b1, '0, 1'b0);
        set_offset(0);
        repeat (2) run_seg(20, 40, 1'b1, 0);
        run_seg(3, 40, 1'b1, 0);
        settle();
        dcheck("verify_bad_slip", slip_pos, 1);
        dcheck("verify_bad_locked", locked, 0);

        // Random streams with random offsets, token mixes and valid gaps
        for (int r = 0; r < 3; r++) begin
            cycle(1'b1, '0, 1'b0);
            set_offset($urandom_range(0, 9));
            repeat (25) run_seg($urandom_range(0, 12), $urandom_range(1, 50), 1'b0, 10);
        end

        settle();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
